// File: rtl/normalizer_stream_writer_if.sv
// Bus bundle for normalizer_stream_writer: spectrum stream in, DMA write port out.
// The master side is the writer, the slave side is the stream source plus the DMA target.
interface normalizer_stream_writer_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 2
);
  localparam int BUS_W = DATA_W * LANES;

  logic [BUS_W-1:0] spect_data;
  logic             spect_valid;
  logic             spect_rdy;
  logic [31:0]      dma_addr;
  logic             dma_write;
  logic [BUS_W-1:0] dma_writedata;
  logic             dma_rdy;

  modport master (
    input  spect_data, spect_valid, dma_rdy,
    output spect_rdy, dma_addr, dma_write, dma_writedata
  );

  modport slave (
    output spect_data, spect_valid, dma_rdy,
    input  spect_rdy, dma_addr, dma_write, dma_writedata
  );
endinterface

// File: rtl/normalizer_stream_writer.sv
// Captures normalized spectrum beats (optionally saturated per lane) and writes them
// to a DMA port one beat at a time, walking an address range with an optional row gap.
module normalizer_stream_writer #(
  parameter int DATA_W    = 16,
  parameter int LANES     = 2,
  parameter int ROW_BEATS = 129,
  parameter int ROW_GAP   = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [31:0]               start_addr,
  input  logic [31:0]               stop_addr,
  input  logic                      row_mode,
  input  logic                      clamp_en,
  input  logic [DATA_W-1:0]         max_value,
  normalizer_stream_writer_if.master bus,
  output logic                      busy,
  output logic                      irq,
  output logic                      overrun,
  output logic [15:0]               beat_count
);

  localparam int          BUS_W    = DATA_W * LANES;
  localparam int          BEAT_B   = BUS_W / 8;
  localparam logic [31:0] ROW_LAST = 32'(ROW_BEATS - 1);
  localparam logic [31:0] ADDR_GAP = 32'(ROW_GAP);
  localparam logic [31:0] ADDR_STEP = 32'(BEAT_B);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WRITE,
    ADVANCE,
    DONE
  } state_t;

  state_t           state_reg;
  logic [31:0]      addr_reg;
  logic [31:0]      row_cnt_reg;
  logic [15:0]      beat_cnt_reg;
  logic [BUS_W-1:0] buf_reg;
  logic             credit_reg;
  logic             overrun_reg;

  logic [BUS_W-1:0] clamped;
  logic             write_fire;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_clamp
      logic [DATA_W-1:0] lane;
      assign lane = bus.spect_data[gi*DATA_W +: DATA_W];
      assign clamped[gi*DATA_W +: DATA_W] = (clamp_en && (lane > max_value)) ? max_value : lane;
    end
  endgenerate

  // A write goes out only while one acknowledge credit is held for the previous write.
  assign write_fire = (state_reg == WRITE) && credit_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= 32'd0;
      row_cnt_reg  <= 32'd0;
      beat_cnt_reg <= 16'd0;
      buf_reg      <= '0;
      credit_reg   <= 1'b0;
      overrun_reg  <= 1'b0;
    end else if (start) begin
      state_reg    <= FETCH;
      addr_reg     <= start_addr;
      row_cnt_reg  <= 32'd0;
      beat_cnt_reg <= 16'd0;
      buf_reg      <= '0;
      credit_reg   <= 1'b1;
      overrun_reg  <= 1'b0;
    end else begin
      // An acknowledge arriving with a write leaves the credit set.
      if (bus.dma_rdy) begin
        credit_reg <= 1'b1;
      end else if (write_fire) begin
        credit_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: state_reg <= IDLE;
        FETCH: begin
          if (bus.spect_valid) begin
            buf_reg   <= clamped;
            state_reg <= WRITE;
          end
        end
        WRITE: begin
          if (credit_reg) begin
            state_reg <= ADVANCE;
          end
        end
        ADVANCE: begin
          beat_cnt_reg <= beat_cnt_reg + 16'd1;
          if (row_mode && (row_cnt_reg == ROW_LAST)) begin
            row_cnt_reg <= 32'd0;
            addr_reg    <= addr_reg + ADDR_GAP;
          end else begin
            row_cnt_reg <= row_cnt_reg + 32'd1;
            addr_reg    <= addr_reg + ADDR_STEP;
          end
          // Termination looks at the address just written, not the advanced one.
          if (addr_reg == stop_addr) begin
            state_reg <= DONE;
          end else if (addr_reg > stop_addr) begin
            overrun_reg <= 1'b1;
            state_reg   <= DONE;
          end else begin
            state_reg <= FETCH;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.spect_rdy     = (state_reg == FETCH) && bus.spect_valid;
  assign bus.dma_write     = write_fire;
  assign bus.dma_addr      = write_fire ? addr_reg : 32'd0;
  assign bus.dma_writedata = write_fire ? buf_reg : '0;

  assign busy       = (state_reg == FETCH) || (state_reg == WRITE) || (state_reg == ADVANCE);
  assign irq        = (state_reg == DONE);
  assign overrun    = overrun_reg;
  assign beat_count = beat_cnt_reg;

endmodule

// File: tb/tb_normalizer_stream_writer.sv
// Directed bench for normalizer_stream_writer: address walk, row gap, clamp,
// credit stall, overrun and mid-transfer reset.
module tb_normalizer_stream_writer;

  localparam int DATA_W = 16;
  localparam int LANES  = 2;

  logic              clk;
  logic              rst;
  logic              start;
  logic [31:0]       start_addr;
  logic [31:0]       stop_addr;
  logic              row_mode;
  logic              clamp_en;
  logic [DATA_W-1:0] max_value;
  logic              busy;
  logic              irq;
  logic              overrun;
  logic [15:0]       beat_count;

  normalizer_stream_writer_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();

  normalizer_stream_writer #(
    .DATA_W   (DATA_W),
    .LANES    (LANES),
    .ROW_BEATS(3),
    .ROW_GAP  (128)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_addr(start_addr),
    .stop_addr (stop_addr),
    .row_mode  (row_mode),
    .clamp_en  (clamp_en),
    .max_value (max_value),
    .bus       (bus),
    .busy      (busy),
    .irq       (irq),
    .overrun   (overrun),
    .beat_count(beat_count)
  );

  int          passed = 0;
  int          total = 0;
  int          cyc = 0;
  int          irq_cnt = 0;
  int          zero_viol = 0;
  int          irq0;
  int          nwr;
  logic        auto_rdy = 1'b1;
  logic        force_rdy = 1'b0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  logic [31:0] exp_row[4] = '{32'h0, 32'h4, 32'h8, 32'h88};
  logic        c_en[3]    = '{1'b1, 1'b1, 1'b0};
  logic [31:0] c_in[3]    = '{32'h0500_0300, 32'h0400_0401, 32'h0500_0300};
  logic [31:0] c_exp[3]   = '{32'h0400_0300, 32'h0400_0400, 32'h0500_0300};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Write log plus idle-bus and irq monitors.
  always @(negedge clk) begin
    if (bus.dma_write) begin
      wr_addr.push_back(bus.dma_addr);
      wr_data.push_back(bus.dma_writedata);
      wr_cyc.push_back(cyc);
      $display("write addr=0x%08h data=0x%08h cycle=%0d", bus.dma_addr, bus.dma_writedata, cyc);
    end else if (bus.dma_addr != 32'd0 || bus.dma_writedata != 32'd0) begin
      zero_viol++;
    end
    if (irq) irq_cnt++;
  end

  // DMA target: acknowledge one cycle after each write unless withheld.
  initial begin
    logic w;
    bus.dma_rdy = 1'b0;
    forever begin
      @(negedge clk);
      w = bus.dma_write;
      @(posedge clk);
      #1;
      bus.dma_rdy = (auto_rdy && w) || force_rdy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic clr();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    irq0 = irq_cnt;
  endtask

  task automatic kick(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start_addr = a;
    stop_addr  = b;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (irq !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(k < budget), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    row_mode = 1'b0;
    clamp_en = 1'b0;
    max_value = '0;
    start_addr = 32'd0;
    stop_addr = 32'd0;
    bus.spect_data = 32'h0005_0003;
    bus.spect_valid = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_outputs", 64'({busy, irq, overrun, bus.dma_write, bus.spect_rdy}), 64'd0);
    chk("rst_beat_count", 64'(beat_count), 64'd0);
    chk("rst_dma_addr", 64'(bus.dma_addr), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_stays", 64'({busy, bus.spect_rdy, bus.dma_write}), 64'd0);

    // Linear walk 0x100..0x10C
    clr();
    kick(32'h100, 32'h10C);
    chk("t1_fetch", 64'({busy, bus.spect_rdy}), 64'b11);
    chk("t1_bc_start", 64'(beat_count), 64'd0);
    wait_done("t1_done", 100);
    chk("t1_nwr", 64'(wr_addr.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", 64'(wr_addr[i]), 64'(32'h100 + 4 * i));
      chk("t1_data", 64'(wr_data[i]), 64'h0005_0003);
    end
    chk("t1_rate01", 64'(wr_cyc[1] - wr_cyc[0]), 64'd3);
    chk("t1_rate23", 64'(wr_cyc[3] - wr_cyc[2]), 64'd3);
    chk("t1_irq", 64'(irq_cnt - irq0), 64'd1);
    chk("t1_beat_count", 64'(beat_count), 64'd4);
    chk("t1_overrun", 64'(overrun), 64'd0);
    chk("t1_idle", 64'(busy), 64'd0);

    // Row mode with 3-beat rows and a 128-byte gap
    clr();
    row_mode = 1'b1;
    kick(32'h0, 32'h88);
    wait_done("t2_done", 100);
    chk("t2_nwr", 64'(wr_addr.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("t2_addr", 64'(wr_addr[i]), 64'(exp_row[i]));
    chk("t2_irq", 64'(irq_cnt - irq0), 64'd1);
    chk("t2_beat_count", 64'(beat_count), 64'd4);
    row_mode = 1'b0;

    // Lane saturation: above, equal to, and disabled
    max_value = 16'h0400;
    for (int i = 0; i < 3; i++) begin
      clr();
      clamp_en = c_en[i];
      bus.spect_data = c_in[i];
      kick(32'h200, 32'h200);
      wait_done("t3_done", 50);
      chk("t3_nwr", 64'(wr_data.size()), 64'd1);
      chk("t3_data", 64'(wr_data[0]), 64'(c_exp[i]));
    end
    clamp_en = 1'b0;

    // Acknowledge withheld after the first write
    clr();
    bus.spect_data = 32'h0011_0022;
    auto_rdy = 1'b0;
    kick(32'h300, 32'h304);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_nowr", 64'(bus.dma_write), 64'd0);
    end
    chk("t4_hold_state", 64'({busy, bus.spect_rdy}), 64'b10);
    chk("t4_nwr_hold", 64'(wr_addr.size()), 64'd1);
    force_rdy = 1'b1;
    @(negedge clk);
    force_rdy = 1'b0;
    chk("t4_rdy_cycle_nowr", 64'(bus.dma_write), 64'd0);
    @(negedge clk);
    chk("t4_second_write", 64'(bus.dma_write), 64'd1);
    chk("t4_second_addr", 64'(bus.dma_addr), 64'h304);
    chk("t4_second_data", 64'(bus.dma_writedata), 64'h0011_0022);
    auto_rdy = 1'b1;
    wait_done("t4_done", 50);
    chk("t4_nwr", 64'(wr_addr.size()), 64'd2);
    chk("t4_irq", 64'(irq_cnt - irq0), 64'd1);

    // Stop address not on a beat boundary
    clr();
    bus.spect_data = 32'h0005_0003;
    kick(32'h0, 32'h6);
    wait_done("t5_done", 100);
    chk("t5_nwr", 64'(wr_addr.size()), 64'd3);
    chk("t5_addr0", 64'(wr_addr[0]), 64'h0);
    chk("t5_addr1", 64'(wr_addr[1]), 64'h4);
    chk("t5_addr2", 64'(wr_addr[2]), 64'h8);
    chk("t5_overrun", 64'(overrun), 64'd1);
    chk("t5_irq", 64'(irq_cnt - irq0), 64'd1);
    kick(32'h400, 32'h400);
    chk("t5_overrun_cleared", 64'(overrun), 64'd0);
    wait_done("t5b_done", 50);

    // Reset while stalled in WRITE, then restart elsewhere
    clr();
    auto_rdy = 1'b0;
    kick(32'h500, 32'h50C);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_rst", 64'({busy, bus.dma_write, irq, overrun}), 64'd0);
    chk("t6_rst_beat_count", 64'(beat_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    auto_rdy = 1'b1;
    nwr = wr_addr.size();
    repeat (6) @(negedge clk);
    chk("t6_no_write_after_rst", 64'(wr_addr.size()), 64'(nwr));
    chk("t6_idle", 64'(busy), 64'd0);
    kick(32'h600, 32'h604);
    chk("t6_bc_start", 64'(beat_count), 64'd0);
    wait_done("t6_done", 100);
    chk("t6_nwr", 64'(wr_addr.size()), 64'(nwr + 2));
    chk("t6_addr0", 64'(wr_addr[nwr]), 64'h600);
    chk("t6_addr1", 64'(wr_addr[nwr + 1]), 64'h604);
    chk("t6_beat_count", 64'(beat_count), 64'd2);

    chk("idle_bus_zero", 64'(zero_viol), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
